// File: rtl/udp_tx_sched.sv
// udp_tx_sched: round-robin two-source scheduler feeding udp_tx, with inter-frame gap, frame counters and watchdog
module udp_tx_sched #(
    parameter logic [15:0] UDP_DATA_NUM = 16'd10,
    parameter int          IFG_CYC      = 12,
    parameter int          TIMEOUT_CYC  = 2048,
    parameter logic [47:0] CH0_MAC      = 48'hff_ff_ff_ff_ff_ff,
    parameter logic [31:0] CH0_IP       = 32'hc0_a8_00_91,
    parameter logic [47:0] CH1_MAC      = 48'hff_ff_ff_ff_ff_ff,
    parameter logic [31:0] CH1_IP       = 32'hc0_a8_00_92
) (
    input  logic        gmii_txc,
    input  logic        rstn,
    input  logic        ch0_req,
    input  logic        ch1_req,
    input  logic [15:0] ch0_data,
    input  logic [15:0] ch1_data,
    output logic        ch0_pop,
    output logic        ch1_pop,
    output logic        udp_tx_en,
    output logic [15:0] udp_tx_data,
    output logic [47:0] des_mac,
    output logic [31:0] des_ip,
    input  logic        udp_data_en,
    input  logic        udp_tx_done,
    output logic        busy,
    output logic        grant_ch,
    output logic [15:0] ch0_frames,
    output logic [15:0] ch1_frames,
    output logic        timeout_err,
    input  logic        err_clr
);
    localparam int GW = $clog2(IFG_CYC + 1);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [1:0] {IDLE, GRANT, SEND, GAP} state_t;
    state_t        state_q, state_d;
    logic          grant_q, grant_d, sel_q, sel_d, ph_q, ph_d, err_q, err_d;
    logic [47:0]   mac_q, mac_d;
    logic [31:0]   ip_q, ip_d;
    logic [15:0]   wcnt_q, wcnt_d, ch0_frames_q, ch0_frames_d, ch1_frames_q, ch1_frames_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          pick, pop_en, wd_hit;
    assign pick   = (ch0_req && ch1_req) ? !grant_q : ch1_req;
    assign pop_en = (state_q == SEND) && udp_data_en && !ph_q && (wcnt_q < UDP_DATA_NUM);
    assign wd_hit = (state_q == SEND) && !udp_tx_done && (wd_q == WW'(TIMEOUT_CYC - 1));
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        sel_d        = sel_q;
        mac_d        = mac_q;
        ip_d         = ip_q;
        wcnt_d       = wcnt_q;
        ph_d         = ph_q;
        gap_d        = gap_q;
        wd_d         = wd_q;
        ch0_frames_d = ch0_frames_q;
        ch1_frames_d = ch1_frames_q;
        err_d        = wd_hit || (err_q && !err_clr);
        case (state_q)
            IDLE: if (ch0_req || ch1_req) begin
                state_d = GRANT;
                grant_d = pick;
                sel_d   = pick;
                mac_d   = pick ? CH1_MAC : CH0_MAC;
                ip_d    = pick ? CH1_IP : CH0_IP;
            end
            GRANT: begin
                state_d = SEND;
                wcnt_d  = '0;
                ph_d    = 1'b0;
                wd_d    = '0;
            end
            SEND: begin
                ph_d   = udp_data_en ? !ph_q : ph_q;
                wcnt_d = wcnt_q + 16'(pop_en);
                wd_d   = (wd_q == WW'(TIMEOUT_CYC)) ? wd_q : wd_q + WW'(1);
                if (udp_tx_done) begin
                    state_d      = GAP;
                    gap_d        = GW'(IFG_CYC - 1);
                    ch0_frames_d = grant_q ? ch0_frames_q : ch0_frames_q + 16'd1;
                    ch1_frames_d = grant_q ? ch1_frames_q + 16'd1 : ch1_frames_q;
                end
            end
            GAP: begin
                state_d = (gap_q == '0) ? IDLE : GAP;
                gap_d   = (gap_q == '0) ? gap_q : gap_q - GW'(1);
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge gmii_txc or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            grant_q      <= 1'b1;
            sel_q        <= 1'b0;
            mac_q        <= CH0_MAC;
            ip_q         <= CH0_IP;
            wcnt_q       <= '0;
            ph_q         <= 1'b0;
            gap_q        <= '0;
            wd_q         <= '0;
            ch0_frames_q <= '0;
            ch1_frames_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            sel_q        <= sel_d;
            mac_q        <= mac_d;
            ip_q         <= ip_d;
            wcnt_q       <= wcnt_d;
            ph_q         <= ph_d;
            gap_q        <= gap_d;
            wd_q         <= wd_d;
            ch0_frames_q <= ch0_frames_d;
            ch1_frames_q <= ch1_frames_d;
            err_q        <= err_d;
        end
    end
    // Enable is gated by done so udp_tx sees it low as it returns to idle and cannot restart.
    assign udp_tx_en   = (state_q == SEND) && !udp_tx_done;
    assign udp_tx_data = sel_q ? ch1_data : ch0_data;
    assign ch0_pop     = pop_en && !grant_q;
    assign ch1_pop     = pop_en && grant_q;
    assign busy        = state_q != IDLE;
    assign grant_ch    = grant_q;
    assign des_mac     = mac_q;
    assign des_ip      = ip_q;
    assign ch0_frames  = ch0_frames_q;
    assign ch1_frames  = ch1_frames_q;
    assign timeout_err = err_q;
endmodule

// File: tb/tb_udp_tx_sched.sv
// tb_udp_tx_sched: randomized bench with a byte-level udp_tx model and FIFO sources checking udp_tx_sched
module tb_udp_tx_sched;
    localparam int N = 10;
    localparam int IFG = 12;
    localparam int TO = 64;
    localparam logic [47:0] MAC0 = 48'hff_ff_ff_ff_ff_ff;
    localparam logic [47:0] MAC1 = 48'h02_12_34_56_78_9a;
    localparam logic [31:0] IP0 = 32'hc0_a8_00_91;
    localparam logic [31:0] IP1 = 32'hc0_a8_00_92;
    logic gmii_txc = 0, rstn = 1, ch0_req = 0, ch1_req = 0, udp_data_en = 0, udp_tx_done = 0, err_clr = 0;
    logic [15:0] ch0_data = 0, ch1_data = 0;
    logic ch0_pop, ch1_pop, udp_tx_en, busy, grant_ch, timeout_err;
    logic [15:0] udp_tx_data, ch0_frames, ch1_frames;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    udp_tx_sched #(.UDP_DATA_NUM(16'(N)), .IFG_CYC(IFG), .TIMEOUT_CYC(TO), .CH1_MAC(MAC1)) dut (
        .gmii_txc(gmii_txc), .rstn(rstn), .ch0_req(ch0_req), .ch1_req(ch1_req),
        .ch0_data(ch0_data), .ch1_data(ch1_data), .ch0_pop(ch0_pop), .ch1_pop(ch1_pop),
        .udp_tx_en(udp_tx_en), .udp_tx_data(udp_tx_data), .des_mac(des_mac), .des_ip(des_ip),
        .udp_data_en(udp_data_en), .udp_tx_done(udp_tx_done), .busy(busy), .grant_ch(grant_ch),
        .ch0_frames(ch0_frames), .ch1_frames(ch1_frames), .timeout_err(timeout_err), .err_clr(err_clr)
    );
    always #5 gmii_txc = ~gmii_txc;
    logic [15:0] q0[$], q1[$];
    logic [7:0]  rx[$];
    logic [15:0] exp_w[N];
    int tests = 0, fails = 0;
    int m_st = 0, m_cnt = 0, hdr_n = 3, tail_n = 2;
    logic m_de = 0, hold_done = 0;
    logic p_en = 0, p_pop0 = 0, p_pop1 = 0;
    logic [15:0] p_data = 0;
    int cyc = 0, last_done = -1, min_gap = 1000000, gaps_seen = 0, en_in_done = 0, bad_pop = 0, bad_des = 0;
    int pops0 = 0, pops1 = 0, base0 = 0, base1 = 0;
    logic last_g = 1'b1, cur_ch = 1'b0;
    logic [15:0] exp_f0 = 0, exp_f1 = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // One clock: apply edge effects seen last cycle (source pops, udp_tx model), drive inputs, then sample.
    task automatic step();
        logic nde;
        @(posedge gmii_txc);
        #1;
        if (p_pop0) begin void'(q0.pop_front()); pops0++; end
        if (p_pop1) begin void'(q1.pop_front()); pops1++; end
        nde = (m_st == 2);
        case (m_st)
            0: if (p_en) begin m_st = 1; m_cnt = 0; end
            1: if (m_cnt >= hdr_n - 1) begin m_st = 2; m_cnt = 0; end else m_cnt++;
            2: begin
                rx.push_back((m_cnt % 2 == 1) ? p_data[7:0] : p_data[15:8]);
                if (m_cnt == 2 * N - 1) begin m_st = 3; m_cnt = 0; end else m_cnt++;
            end
            3: if (!hold_done && m_cnt >= tail_n - 1) m_st = 4; else m_cnt++;
            default: m_st = 0;
        endcase
        m_de = nde;
        udp_tx_done = (m_st == 4);
        udp_data_en = m_de;
        ch0_data = (q0.size() > 0) ? q0[0] : 16'hdead;
        ch1_data = (q1.size() > 0) ? q1[0] : 16'hdead;
        #1;
        if (udp_tx_en && !p_en && last_done >= 0) begin
            gaps_seen++;
            if (cyc - last_done < min_gap) min_gap = cyc - last_done;
        end
        if (udp_tx_done) begin
            last_done = cyc;
            if (udp_tx_en) en_in_done++;
        end
        if ((ch0_pop && ch1_pop) || ((ch0_pop || ch1_pop) && !udp_tx_en) || (ch0_pop && grant_ch) || (ch1_pop && !grant_ch))
            bad_pop++;
        if (busy && (des_ip !== (grant_ch ? IP1 : IP0) || des_mac !== (grant_ch ? MAC1 : MAC0)))
            bad_des++;
        p_en = udp_tx_en;
        p_pop0 = ch0_pop;
        p_pop1 = ch1_pop;
        p_data = udp_tx_data;
        cyc++;
    endtask
    task automatic check_reset();
        check("rst_udp_tx_en", udp_tx_en, 0);
        check("rst_ch0_pop", ch0_pop, 0);
        check("rst_ch1_pop", ch1_pop, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_ch", grant_ch, 1);
        check("rst_des_mac", des_mac, MAC0);
        check("rst_des_ip", des_ip, IP0);
        check("rst_ch0_frames", ch0_frames, 0);
        check("rst_ch1_frames", ch1_frames, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_tx_data_ch0", udp_tx_data, ch0_data);
    endtask
    task automatic do_reset();
        rstn = 0;
        #1;
        check_reset();
        m_st = 0; m_cnt = 0; m_de = 0; hold_done = 0;
        udp_tx_done = 0; udp_data_en = 0;
        p_en = 0; p_pop0 = 0; p_pop1 = 0;
        last_done = -1; rx.delete();
        last_g = 1'b1; exp_f0 = 0; exp_f1 = 0;
        ch0_req = 0; ch1_req = 0; err_clr = 0;
        repeat (3) step();
        rstn = 1;
        repeat (2) step();
    endtask
    task automatic start_frame(input logic r0, input logic r1, input logic idle_chk);
        int k;
        cur_ch = (r0 && r1) ? !last_g : r1;
        last_g = cur_ch;
        for (int i = 0; i < N; i++) exp_w[i] = cur_ch ? q1[i] : q0[i];
        base0 = pops0;
        base1 = pops1;
        rx.delete();
        hdr_n = $urandom_range(1, 6);
        tail_n = $urandom_range(1, 4);
        ch0_req = r0;
        ch1_req = r1;
        k = 0;
        do begin step(); k++; end while (!udp_tx_en && k < 100);
        check("en_rise", udp_tx_en, 1);
        if (idle_chk) check("req_to_en_latency", k, 2);
        check("grant_ch", grant_ch, cur_ch);
        check("des_mac", des_mac, cur_ch ? MAC1 : MAC0);
        check("des_ip", des_ip, cur_ch ? IP1 : IP0);
    endtask
    task automatic finish_frame();
        int k;
        k = 0;
        while (!udp_tx_done && k < 400) begin step(); k++; end
        check("done_seen", udp_tx_done, 1);
        step();
        if (cur_ch) exp_f1 = exp_f1 + 16'd1;
        else exp_f0 = exp_f0 + 16'd1;
        check("pops_granted", cur_ch ? pops1 - base1 : pops0 - base0, N);
        check("pops_other", cur_ch ? pops0 - base0 : pops1 - base1, 0);
        check("rx_len", rx.size(), 2 * N);
        for (int i = 0; i < N && 2 * i + 1 < rx.size(); i++)
            check("payload_word", {rx[2*i], rx[2*i+1]}, exp_w[i]);
        check("ch0_frames", ch0_frames, exp_f0);
        check("ch1_frames", ch1_frames, exp_f1);
    endtask
    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1);
    end
    initial begin
        int k, hi;
        logic [1:0] r;
        logic drop;
        for (int i = 1; i <= N; i++) q0.push_back(16'(i));
        q1.push_back(16'hbeef);
        repeat (400) begin
            q0.push_back(16'($urandom));
            q1.push_back(16'($urandom));
        end
        step();
        do_reset();
        start_frame(1, 0, 1);
        ch0_req = 0;
        finish_frame();
        repeat (IFG + 4) step();
        do_reset();
        for (int f = 0; f < 4; f++) begin
            start_frame(1, 1, 0);
            finish_frame();
        end
        ch0_req = 0;
        ch1_req = 0;
        check("min_gap_ge_ifg_plus_1", min_gap >= IFG + 1, 1);
        check("gaps_measured", gaps_seen >= 3, 1);
        check("en_low_in_done_cycle", en_in_done, 0);
        repeat (20) step();
        hold_done = 1;
        start_frame(1, 0, 1);
        ch0_req = 0;
        check("err_low_at_send_start", timeout_err, 0);
        k = 1;
        while (!timeout_err && k < 300) begin
            step();
            if (!timeout_err) k++;
        end
        check("timeout_send_cycles", k, TO);
        check("timeout_err_set", timeout_err, 1);
        check("en_high_at_timeout", udp_tx_en, 1);
        repeat (20) step();
        check("timeout_sticky", timeout_err, 1);
        check("en_held_in_timeout", udp_tx_en, 1);
        err_clr = 1;
        step();
        err_clr = 0;
        step();
        check("err_clr_clears", timeout_err, 0);
        hold_done = 0;
        finish_frame();
        repeat (20) step();
        err_clr = 1;
        hold_done = 1;
        start_frame(0, 1, 1);
        ch1_req = 0;
        hi = 0;
        repeat (TO + 20) begin
            step();
            if (timeout_err) hi++;
        end
        check("set_wins_over_clr", hi, 1);
        err_clr = 0;
        hold_done = 0;
        finish_frame();
        repeat (20) step();
        start_frame(1, 0, 1);
        ch0_req = 0;
        k = 0;
        while (pops0 - base0 < 3 && k < 100) begin step(); k++; end
        check("three_pops_before_reset", pops0 - base0, 3);
        check("en_high_before_reset", udp_tx_en, 1);
        do_reset();
        start_frame(1, 0, 1);
        ch0_req = 0;
        finish_frame();
        repeat (20) step();
        force dut.ch1_frames_q = 16'hffff;
        step();
        release dut.ch1_frames_q;
        step();
        check("ch1_frames_preload", ch1_frames, 16'hffff);
        exp_f1 = 16'hffff;
        start_frame(0, 1, 1);
        ch1_req = 0;
        finish_frame();
        check("ch1_frames_wrap", ch1_frames, 16'h0000);
        repeat (12) begin
            r = 2'($urandom_range(1, 3));
            drop = 1'($urandom_range(0, 1));
            start_frame(r[0], r[1], 0);
            if (drop) begin
                ch0_req = 0;
                ch1_req = 0;
            end
            finish_frame();
        end
        ch0_req = 0;
        ch1_req = 0;
        repeat (20) step();
        check("pop_rules", bad_pop, 0);
        check("des_rules", bad_des, 0);
        check("final_timeout_err", timeout_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
